psum_requant_buf: RTL

- Downstream stage of the 3-row adder tree; consumes its 32-bit signed sum and valid strobe.
- Accumulates a configured number of adder-tree sums per output pixel (input-channel passes) and adds a bias.
- Applies optional ReLU, a rounding right shift and saturation to a signed 8-bit activation.
- Buffers results in a small FIFO with a valid/ready output, because the adder tree has no backpressure.

---
 rtl/psum_requant_buf.sv | 122 ++++++++++++
 1 files changed

// File: rtl/psum_requant_buf.sv
// psum_requant_buf: accumulate adder-tree sums per pixel, add bias, requantize to int8 and buffer in a FIFO
module psum_requant_buf #(
  parameter int IN_W       = 32,
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              in_valid,
  input  logic [IN_W-1:0]                   in_sum,
  input  logic [7:0]                        cfg_num_pass,
  input  logic [31:0]                       cfg_bias,
  input  logic [4:0]                        cfg_shift,
  input  logic                              cfg_relu,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [OUT_W-1:0]                  out_data,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic                              err_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] MINV = -(ACC_W+1)'(2**(OUT_W-1));

  logic [7:0]              cnt_q, cnt_d, np_q, np_cur;
  logic [4:0]              sh_q, sh_cur, res_sh_q;
  logic                    relu_q, relu_cur, res_relu_q, res_v_q;
  logic                    first, last;
  logic signed [ACC_W-1:0] acc_q, base, sum, res_q;
  logic signed [ACC_W:0]   v, rnd, shf;
  logic [OUT_W-1:0]        q;
  logic [OUT_W-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]           wp_q, rp_q;
  logic [CW-1:0]           cnt_fifo_q;
  logic                    ovf_q, pop, full, wr, drop;

  // Pixel bookkeeping: on the first beat the live config is used and latched for later beats
  always_comb begin
    first    = cnt_q == 8'd0;
    np_cur   = first ? (cfg_num_pass == 8'd0 ? 8'd1 : cfg_num_pass) : np_q;
    sh_cur   = first ? cfg_shift : sh_q;
    relu_cur = first ? cfg_relu : relu_q;
    base     = first ? ACC_W'($signed(cfg_bias)) : acc_q;
    sum      = base + ACC_W'($signed(in_sum));
    last     = cnt_q == np_cur - 8'd1;
    cnt_d    = last ? 8'd0 : cnt_q + 8'd1;
  end

  // Accumulator, pass counter, config latch and the single-entry result stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      cnt_q      <= '0;
      np_q       <= '0;
      sh_q       <= '0;
      relu_q     <= 1'b0;
      acc_q      <= '0;
      res_q      <= '0;
      res_sh_q   <= '0;
      res_relu_q <= 1'b0;
      res_v_q    <= 1'b0;
    end else begin
      res_v_q <= in_valid && last;
      if (in_valid) begin
        cnt_q <= cnt_d;
        acc_q <= sum;
        if (first) begin
          np_q   <= np_cur;
          sh_q   <= sh_cur;
          relu_q <= relu_cur;
        end
        if (last) begin
          res_q      <= sum;
          res_sh_q   <= sh_cur;
          res_relu_q <= relu_cur;
        end
      end
    end
  end

  // Requantize the result stage: optional ReLU, round-half-up right shift, saturate
  always_comb begin
    v   = (res_relu_q && res_q < 0) ? '0 : (ACC_W+1)'(res_q);
    rnd = res_sh_q == 5'd0 ? v : v + ((ACC_W+1)'(1) <<< (res_sh_q - 5'd1));
    shf = rnd >>> res_sh_q;
    q   = shf > MAXV ? MAXV[OUT_W-1:0] : shf < MINV ? MINV[OUT_W-1:0] : shf[OUT_W-1:0];
  end

  // FIFO control: a full FIFO still accepts a push when the head is popped in the same cycle
  always_comb begin
    out_valid  = cnt_fifo_q != '0;
    out_data   = out_valid ? mem[rp_q] : '0;
    fifo_count = cnt_fifo_q;
    err_ovf    = ovf_q;
    pop        = out_valid && out_ready && !clear;
    full       = cnt_fifo_q == CW'(FIFO_DEPTH);
    wr         = res_v_q && (!full || pop) && !clear;
    drop       = res_v_q && full && !pop && !clear;
  end

  // FIFO storage; stale entries are never visible because out_data is masked when empty
  always_ff @(posedge clk) begin
    if (wr) mem[wp_q] <= q;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_fifo_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wp_q       <= wp_q + AW'(wr);
      rp_q       <= rp_q + AW'(pop);
      cnt_fifo_q <= cnt_fifo_q + CW'(wr) - CW'(pop);
      ovf_q      <= ovf_q || drop;
    end
  end
endmodule
